// File: rtl/sm83_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_pkg
//  Description : Shared SM83 bus types, the wait-state memory FSM encoding and
//                the constants returned on the data bus for special accesses.
//  Contents    : addr_t, data_t, mem_state_t, MEM_OPEN_BUS, MEM_WR_DATA,
//                addr_below()
//  Revision    : 1.0 - initial release
// ============================================================================
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  // Memory model handshake states: waiting for a request, counting wait
  // states, presenting the one-cycle response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Value driven on reads that fall outside the implemented array.
  localparam data_t MEM_OPEN_BUS = 8'hFF;
  // Value driven on the data bus while a write completes.
  localparam data_t MEM_WR_DATA  = 8'h00;

  // Full 16-bit compare against a limit that may be 65536, so the compare is
  // done at 17 bits; nothing aliases or wraps back into the array.
  function automatic logic addr_below(input addr_t a, input int unsigned lim);
    return {1'b0, a} < 17'(lim);
  endfunction

endpackage : sm83_pkg
`default_nettype wire

// File: rtl/sm83_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_mem_array
//  Description : DEPTH x 8-bit storage with one synchronous read port and one
//                synchronous write port. No reset, so it maps onto block RAM.
//                A read issued on the same edge as a write to the same index
//                returns the new data (write-first).
//  Ports       : clk      - clock
//                rd_en    - capture mem[rd_addr] into rd_data on this edge
//                rd_addr  - read index
//                rd_data  - registered read data, holds between reads
//                wr_en    - write wr_data to mem[wr_addr] on this edge
//                wr_addr  - write index
//                wr_data  - write data
//  Revision    : 1.0 - initial release
// ============================================================================
module sm83_mem_array
  import sm83_pkg::*;
#(
  parameter int    DEPTH     = 8192,
  parameter int    ADDR_W    = 13,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output data_t             rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  data_t             wr_data
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule : sm83_mem_array
`default_nettype wire

// File: rtl/sm83_wait_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_wait_mem
//  Description : SM83 memory model with a req/ready handshake and LAT
//                programmable wait states, a write-protected ROM region at the
//                bottom of the map, open-bus reads above DEPTH and an error
//                flag qualifying each completion.
//  Ports       : clk    - clock, all state on posedge
//                rst_n  - asynchronous active-low reset
//                req    - request, sampled in IDLE and RESP only
//                we     - 1 = write, 0 = read (captured with req)
//                addr   - byte address (captured with req)
//                wdata  - write data (captured with req)
//                rdata  - read data, valid while ready=1, held otherwise
//                ready  - one-cycle completion pulse
//                err    - with ready: ROM write dropped or address >= DEPTH
//                busy   - high from acceptance until the cycle before ready
//  Revision    : 1.0 - initial release
// ============================================================================
module sm83_wait_mem
  import sm83_pkg::*;
#(
  parameter int    DEPTH     = 8192,
  parameter string INIT_FILE = "",
  parameter int    LAT       = 2,
  parameter int    ROM_BYTES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_oor;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr_idx;
  data_t             r_wdata;
  data_t             r_rdata_hold;

  logic              w_accept;
  logic              w_in_oor;
  logic              w_in_rom;
  logic              w_issue_now;
  logic              w_issue_wait;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_wr_en;
  data_t             w_arr_rdata;
  data_t             w_resp_data;

  // A new request is taken whenever no wait phase is running, which makes
  // RESP behave like IDLE for back-to-back transfers.
  assign w_accept = req && (r_state != WAIT);
  assign w_in_oor = !addr_below(addr, DEPTH);
  assign w_in_rom = addr_below(addr, ROM_BYTES);

  // The array read is launched one edge ahead of RESP so its registered
  // output lines up with the ready pulse. With no wait states that edge is
  // the acceptance edge itself, so the incoming address goes straight in.
  assign w_issue_now  = w_accept && !we && !w_in_oor && (LAT == 0);
  assign w_issue_wait = (r_state == WAIT) && (r_cnt == 4'd1) && !r_we && !r_oor;
  assign w_rd_en      = w_issue_now || w_issue_wait;
  assign w_rd_addr    = w_issue_now ? addr[ADDR_W-1:0] : r_addr_idx;

  // Writes commit on the RESP edge. r_err already folds in both the range
  // and ROM checks, so a clear flag means the write is allowed.
  assign w_wr_en = (r_state == RESP) && r_we && !r_err;

  sm83_mem_array #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (w_arr_rdata),
    .wr_en   (w_wr_en),
    .wr_addr (r_addr_idx),
    .wr_data (r_wdata)
  );

  always_comb begin
    w_resp_data = w_arr_rdata;
    if (r_we) begin
      w_resp_data = MEM_WR_DATA;
    end else if (r_oor) begin
      w_resp_data = MEM_OPEN_BUS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
      r_err      <= 1'b0;
      r_addr_idx <= '0;
      r_wdata    <= 8'h00;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (req) begin
            r_we       <= we;
            r_oor      <= w_in_oor;
            r_err      <= w_in_oor || (we && w_in_rom);
            r_addr_idx <= addr[ADDR_W-1:0];
            r_wdata    <= wdata;
            r_cnt      <= 4'(LAT);
            r_state    <= (LAT == 0) ? RESP : WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Keeps the last response visible on rdata between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_hold <= 8'h00;
    end else if (r_state == RESP) begin
      r_rdata_hold <= w_resp_data;
    end
  end

  assign ready = (r_state == RESP);
  assign busy  = (r_state == WAIT);
  assign err   = ready && r_err;
  assign rdata = ready ? w_resp_data : r_rdata_hold;

endmodule : sm83_wait_mem
`default_nettype wire

// File: tb/tb_sm83_wait_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm83_wait_mem
//  Description : Self-checking bench for sm83_wait_mem. Two instances with
//                different DEPTH/LAT/ROM_BYTES are driven one after the other
//                with directed and random transactions; each is compared every
//                cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sm83_wait_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [7:0]  wdata [2];
  logic [7:0]  rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  sm83_wait_mem #(
    .DEPTH(8192), .INIT_FILE(""), .LAT(2), .ROM_BYTES(256)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0]),
    .busy(busy[0])
  );

  sm83_wait_mem #(
    .DEPTH(4096), .INIT_FILE(""), .LAT(0), .ROM_BYTES(0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1]),
    .busy(busy[1])
  );

  // Instance configuration as seen by the model.
  int cfg_depth [2] = '{8192, 4096};
  int cfg_lat   [2] = '{2, 0};
  int cfg_rom   [2] = '{256, 0};

  // Reference model: byte contents plus which bytes are known (array is not
  // preloaded, so a byte becomes known on its first write or first read).
  logic [7:0] mem_m   [2][65536];
  bit         known_m [2][65536];
  bit         p_valid [2];
  longint     p_due   [2];
  bit         p_we    [2];
  int         p_addr  [2];
  logic [7:0] p_wdata [2];
  logic [7:0] last_rd [2];

  longint cyc;
  int     n_chk;
  int     n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle for instance k: check this cycle's outputs against the
  // model, retire a completing access, then present the next inputs.
  task automatic step(input int k, input bit r, input bit w, input int a, input logic [7:0] d);
    bit         exp_rdy;
    bit         exp_busy;
    bit         exp_err;
    bit         rd_known;
    logic [7:0] exp_data;
    @(negedge clk);
    exp_rdy  = p_valid[k] && (cyc == p_due[k]);
    exp_busy = p_valid[k] && (cyc < p_due[k]);
    exp_err  = 1'b0;
    exp_data = last_rd[k];
    rd_known = 1'b1;
    if (exp_rdy) begin
      if (p_we[k]) begin
        exp_err  = (p_addr[k] >= cfg_depth[k]) || (p_addr[k] < cfg_rom[k]);
        exp_data = 8'h00;
      end else if (p_addr[k] >= cfg_depth[k]) begin
        exp_err  = 1'b1;
        exp_data = 8'hFF;
      end else if (known_m[k][p_addr[k]]) begin
        exp_data = mem_m[k][p_addr[k]];
      end else begin
        rd_known = 1'b0;
      end
    end
    chk("ready", 32'(ready[k]), 32'(exp_rdy));
    chk("busy", 32'(busy[k]), 32'(exp_busy));
    chk("err", 32'(err[k]), 32'(exp_err));
    if (rd_known) begin
      chk("rdata", 32'(rdata[k]), 32'(exp_data));
    end else begin
      mem_m[k][p_addr[k]]   = rdata[k];
      known_m[k][p_addr[k]] = 1'b1;
      exp_data              = rdata[k];
    end
    if (exp_rdy) begin
      if (p_we[k] && !exp_err) begin
        mem_m[k][p_addr[k]]   = p_wdata[k];
        known_m[k][p_addr[k]] = 1'b1;
      end
      p_valid[k] = 1'b0;
    end
    last_rd[k] = exp_data;

    req[k]   = r;
    we[k]    = w;
    addr[k]  = 16'(a);
    wdata[k] = d;
    if (r && !p_valid[k]) begin
      p_valid[k] = 1'b1;
      p_due[k]   = cyc + longint'(cfg_lat[k]) + 1;
      p_we[k]    = w;
      p_addr[k]  = a & 32'hFFFF;
      p_wdata[k] = d;
    end
    cyc++;
  endtask

  // Present a transaction on the first cycle it can be accepted; while the
  // previous one is still waiting, req and the other inputs carry noise.
  task automatic issue(input int k, input bit w, input int a, input logic [7:0] d);
    while (p_valid[k] && (cyc != p_due[k])) begin
      step(k, 1'($urandom), 1'($urandom), int'($urandom_range(0, 65535)), 8'($urandom));
    end
    step(k, 1'b1, w, a, d);
  endtask

  task automatic drain(input int k);
    while (p_valid[k]) begin
      step(k, 1'b0, 1'b0, 0, 8'h00);
    end
    step(k, 1'b0, 1'b0, 0, 8'h00);
  endtask

  // Assert reset between edges and check the outputs drop at once.
  task automatic reset_now();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(ready[k]), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
      chk("rst_rdata", 32'(rdata[k]), 32'd0);
      p_valid[k] = 1'b0;
      last_rd[k] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rand_addr(input int k);
    int sel;
    sel = int'($urandom_range(0, 3));
    if (k == 0) begin
      case (sel)
        0:       return 32'h00F8 + int'($urandom_range(0, 15));
        1:       return 32'h1FF8 + int'($urandom_range(0, 15));
        2:       return 32'h8FF8 + int'($urandom_range(0, 15));
        default: return 32'h0400 + int'($urandom_range(0, 15));
      endcase
    end else begin
      case (sel)
        0:       return 32'h0FF8 + int'($urandom_range(0, 15));
        1:       return 32'h0000 + int'($urandom_range(0, 15));
        2:       return 32'hFFF0 + int'($urandom_range(0, 15));
        default: return 32'h0800 + int'($urandom_range(0, 15));
      endcase
    end
  endfunction

  task automatic random_run(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drain(k);
      end
      issue(k, 1'($urandom), rand_addr(k), 8'($urandom));
    end
    drain(k);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k]     = 1'b0;
      we[k]      = 1'b0;
      addr[k]    = 16'h0000;
      wdata[k]   = 8'h00;
      p_valid[k] = 1'b0;
      p_due[k]   = 0;
      last_rd[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(ready[k]), 32'd0);
      chk("reset_busy", 32'(busy[k]), 32'd0);
      chk("reset_err", 32'(err[k]), 32'd0);
      chk("reset_rdata", 32'(rdata[k]), 32'd0);
    end
    rst_n = 1'b1;

    // ---- instance 0: DEPTH 8192, LAT 2, ROM 0x000-0x0FF ----
    issue(0, 1'b1, 32'h0100, 8'h5A);   // first writable byte
    issue(0, 1'b0, 32'h0100, 8'h00);   // back-to-back read sees new data
    drain(0);
    issue(0, 1'b1, 32'h1010, 8'h3E);
    drain(0);
    step(0, 1'b0, 1'b0, 0, 8'h00);
    issue(0, 1'b0, 32'h1010, 8'h00);   // isolated read, LAT+1 latency
    drain(0);
    issue(0, 1'b0, 32'h0005, 8'h00);   // learn the ROM byte
    issue(0, 1'b1, 32'h0005, 8'hAA);   // dropped, err
    issue(0, 1'b0, 32'h0005, 8'h00);   // unchanged
    issue(0, 1'b1, 32'h00FF, 8'h77);   // last ROM byte, dropped
    issue(0, 1'b1, 32'h1000, 8'h42);
    issue(0, 1'b0, 32'h9000, 8'h00);   // open bus
    issue(0, 1'b1, 32'h9000, 8'h99);   // out of range write
    issue(0, 1'b0, 32'h1000, 8'h00);   // no aliasing into 0x1000
    issue(0, 1'b0, 32'h1FFF, 8'h00);   // last implemented byte
    issue(0, 1'b0, 32'h2000, 8'h00);   // first byte past DEPTH
    issue(0, 1'b1, 32'h0200, 8'h11);
    drain(0);
    issue(0, 1'b1, 32'h0200, 8'h77);   // abandoned by reset during WAIT
    step(0, 1'b0, 1'b0, 0, 8'h00);
    reset_now();
    issue(0, 1'b0, 32'h0200, 8'h00);   // still 0x11
    drain(0);
    random_run(0, 300);

    // ---- instance 1: DEPTH 4096, LAT 0, no ROM ----
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b1, 32'h0300 + i, 8'(8'hC0 + i));
    end
    drain(1);
    for (int i = 0; i < 4; i++) begin
      issue(1, 1'b0, 32'h0300 + i, 8'h00);   // req held four cycles
    end
    drain(1);
    issue(1, 1'b1, 32'h0310, 8'hC3);
    issue(1, 1'b0, 32'h0310, 8'h00);     // read on the write's RESP edge
    issue(1, 1'b1, 32'h0310, 8'h3C);
    issue(1, 1'b0, 32'h0310, 8'h00);
    issue(1, 1'b1, 32'h0000, 8'h01);     // address 0 writable without ROM
    issue(1, 1'b0, 32'h0000, 8'h00);
    issue(1, 1'b0, 32'h1000, 8'h00);     // first byte past DEPTH
    drain(1);
    random_run(1, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule : tb_sm83_wait_mem
`default_nettype wire
